kamacore_mem_responder: RTL



---
 rtl/kamacore_mem_responder_if.sv | 46 ++++
 rtl/kamacore_mem_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/kamacore_mem_responder_if.sv
// Data-memory request/response bundle between the MEM-stage
// initiator (master) and the memory responder (slave).
interface kamacore_mem_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_be;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      output req_be,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      input  req_be,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_rdata,
      output rsp_err
   );

endinterface

// File: rtl/kamacore_mem_responder.sv
// Data-side memory responder: one request in flight, programmable
// wait states, word array with byte-enabled stores and fault check.
module kamacore_mem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic                     clk,
   input logic                     rst,
   kamacore_mem_responder_if.slave bus
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t state_q;
   state_t state_d;

   logic                  ready_q;
   logic [3:0]            cnt_q;

   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [BE_W-1:0]       lat_be;

   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             rsp_fire;
   logic             fault;
   logic [IDX_W-1:0] idx;

   assign accept   = (state_q == S_IDLE) && ready_q && bus.req_valid;
   assign rsp_fire = (state_q == S_RESP) && bus.rsp_ready;

   // Misaligned, or any address bit above the array span is set;
   // the address is never wrapped into the array.
   assign idx   = lat_addr[IDX_W+1:2];
   assign fault = (|lat_addr[1:0]) || (|(lat_addr >> (IDX_W + 2)));

   // State register; ready is registered so it stays low under reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == S_IDLE);
      end
   end

   // Next-state decode for the request/wait/access/response sequence.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded straight from registers only.
   always_comb begin
      bus.req_ready = ready_q;
      bus.rsp_valid = (state_q == S_RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
   end

   // Wait-state counter: loaded at acceptance, counts down in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else if (accept) begin
         cnt_q <= 4'(WAIT_STATES);
      end else if (state_q == S_WAIT) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Request fields are captured once, at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else if (accept) begin
         lat_we    <= bus.req_we;
         lat_addr  <= bus.req_addr;
         lat_wdata <= bus.req_wdata;
         lat_be    <= bus.req_be;
      end
   end

   // Response data/error: set at ACCESS exit, cleared on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state_q == S_ACCESS) begin
         err_q   <= fault;
         rdata_q <= (fault || lat_we) ? '0 : mem[idx];
      end else if (rsp_fire) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end
   end

   // Byte-enabled store; reset at the ACCESS exit edge cancels it.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == S_ACCESS) && lat_we && !fault) begin
         for (int i = 0; i < BE_W; i++) begin
            if (lat_be[i]) begin
               mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
